popcount_engine: RTL and testbench

POPCOUNT_ENGINE -- requirements
Module: popcount_engine

---
 rtl/popcount_engine_if.sv | 25 ++
 rtl/popcount_engine.sv | 142 ++++++++++++++
 tb/tb_popcount_engine.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/popcount_engine_if.sv
// Handshake and result bundle for popcount_engine: word-in channel plus result-out channel.
interface popcount_engine_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
);
  logic [DATA_W-1:0] data_in;
  logic              in_valid;
  logic              in_ready;
  logic [CNT_W-1:0]  one_count;
  logic [CNT_W-1:0]  zero_count;
  logic              balanced;
  logic              majority;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, one_count, zero_count, balanced, majority, out_valid
  );

  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, one_count, zero_count, balanced, majority, out_valid
  );
endinterface

// File: rtl/popcount_engine.sv
// Multi-cycle popcount: counts CHUNK_W bits per cycle over a latched word, then holds the result.
// Optional running total of one_count across completed words is enabled by POPCOUNT_ACCUM_EN.
module popcount_engine #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef POPCOUNT_ACCUM_EN
  input  logic             accum_clr,
  output logic [31:0]      accum_count,
`endif
  popcount_engine_if.slave bus
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  part_q, part_d;
  logic [CNT_W-1:0]  one_q, one_d;
  logic [CNT_W-1:0]  zero_q, zero_d;
  logic              bal_q, bal_d;
  logic              maj_q, maj_d;

  // Ripple prefix sum over the low slice of the shift register.
  logic [CNT_W-1:0]  prefix [0:CHUNK_W];
  logic [CNT_W-1:0]  part_sum;
  logic [CNT_W-1:0]  zero_sum;

  assign prefix[0] = '0;
  generate
    for (genvar gi = 0; gi < CHUNK_W; gi++) begin : g_bit
      assign prefix[gi+1] = prefix[gi] + CNT_W'(shift_q[gi]);
    end
  endgenerate

  assign part_sum = part_q + prefix[CHUNK_W];
  assign zero_sum = CNT_W'(DATA_W) - part_sum;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    part_d  = part_q;
    one_d   = one_q;
    zero_d  = zero_q;
    bal_d   = bal_q;
    maj_d   = maj_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shift_d = bus.data_in;
          idx_d   = '0;
          part_d  = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        part_d  = part_sum;
        shift_d = shift_q >> CHUNK_W;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NCHUNK - 1)) begin
          idx_d   = '0;
          one_d   = part_sum;
          zero_d  = zero_sum;
          bal_d   = (part_sum == zero_sum);
          maj_d   = (part_sum > zero_sum);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      part_q  <= '0;
      one_q   <= '0;
      zero_q  <= '0;
      bal_q   <= 1'b0;
      maj_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      part_q  <= part_d;
      one_q   <= one_d;
      zero_q  <= zero_d;
      bal_q   <= bal_d;
      maj_q   <= maj_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.one_count  = one_q;
  assign bus.zero_count = zero_q;
  assign bus.balanced   = bal_q;
  assign bus.majority   = maj_q;

`ifdef POPCOUNT_ACCUM_EN
  logic [31:0] accum_q, accum_d;
  logic [32:0] accum_sum;

  assign accum_sum = {1'b0, accum_q} + 33'(one_q);

  // Clear wins over a same-cycle add; the total sticks at all-ones instead of wrapping.
  always_comb begin
    accum_d = accum_q;
    if (accum_clr) begin
      accum_d = '0;
    end else if (state_q == DONE && bus.out_ready) begin
      accum_d = accum_sum[32] ? 32'hFFFF_FFFF : accum_sum[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum_q <= '0;
    end else begin
      accum_q <= accum_d;
    end
  end

  assign accum_count = accum_q;
`endif

endmodule

// File: tb/tb_popcount_engine.sv
// Directed bench for popcount_engine (DATA_W=32, CHUNK_W=8) with a scoreboard of expected results.
module tb_popcount_engine;

  localparam int DATA_W  = 32;
  localparam int CHUNK_W = 8;
  localparam int NCHUNK  = DATA_W / CHUNK_W;

  typedef struct {
    logic [31:0] one;
    logic [31:0] zero;
    logic        bal;
    logic        maj;
    int unsigned acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;
  int          fail_cnt = 0;
  int          overlap_viol = 0;
  exp_t        sb[$];

  popcount_engine_if #(.DATA_W(DATA_W)) bus();

`ifdef POPCOUNT_ACCUM_EN
  logic        accum_clr;
  logic [31:0] accum_count;
`endif

  popcount_engine #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef POPCOUNT_ACCUM_EN
    .accum_clr  (accum_clr),
    .accum_count(accum_count),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.in_ready && bus.out_valid) overlap_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w);
    exp_t e;
    int   n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.data_in  = w;
    bus.in_valid = 1'b1;
    tick();
    e.one     = 32'($countones(w));
    e.zero    = 32'(DATA_W) - e.one;
    e.bal     = (e.one == e.zero);
    e.maj     = (e.one > e.zero);
    e.acc_cyc = cyc;
    sb.push_back(e);
    last_acc     = cyc;
    bus.in_valid = 1'b0;
    bus.data_in  = $urandom;
  endtask

  task automatic recv(input int hold, input bit clr_hs);
    exp_t e;
    int   n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("out_valid_wait", 32'(bus.out_valid), 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    if (!bus.out_valid) return;
    check("latency", cyc - e.acc_cyc, 32'(NCHUNK));
    check("one_count", 32'(bus.one_count), e.one);
    check("zero_count", 32'(bus.zero_count), e.zero);
    check("balanced", 32'(bus.balanced), 32'(e.bal));
    check("majority", 32'(bus.majority), 32'(e.maj));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.data_in  = $urandom;
      tick();
      check("hold_one_count", 32'(bus.one_count), e.one);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    $display("txn one=%0d zero=%0d bal=%0b maj=%0b at cycle %0d",
             bus.one_count, bus.zero_count, bus.balanced, bus.majority, cyc);
    bus.out_ready = 1'b1;
`ifdef POPCOUNT_ACCUM_EN
    accum_clr = clr_hs;
`endif
    tick();
    bus.out_ready = 1'b0;
`ifdef POPCOUNT_ACCUM_EN
    accum_clr = 1'b0;
`endif
  endtask

  initial begin
    int unsigned a0;
    int          seen_valid;
    rst_n         = 1'b0;
    bus.data_in   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
`ifdef POPCOUNT_ACCUM_EN
    accum_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_one_count", 32'(bus.one_count), 32'd0);
    check("rst_zero_count", 32'(bus.zero_count), 32'd0);
    check("rst_balanced", 32'(bus.balanced), 32'd0);
    check("rst_majority", 32'(bus.majority), 32'd0);
    rst_n = 1'b1;

    // First word goes in on the very first edge after release.
    a0 = cyc;
    send(32'h0000_0000);
    check("first_accept_edge", last_acc - a0, 32'd1);
    recv(0, 1'b0);
    send(32'hFFFF_FFFF);
    recv(0, 1'b0);
    send(32'h0000_FFFF);
    recv(0, 1'b0);
    send(32'h8000_0001);
    recv(5, 1'b0);

    // Abort mid-count with reset.
    send(32'hFFFF_FFFF);
    tick();
    tick();
    rst_n = 1'b0;
    void'(sb.pop_back());
    tick();
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) seen_valid++;
    end
    check("abort_no_valid", 32'(seen_valid), 32'd0);
    check("abort_one_count", 32'(bus.one_count), 32'd0);
    check("abort_zero_count", 32'(bus.zero_count), 32'd0);
    check("abort_balanced", 32'(bus.balanced), 32'd0);
    check("abort_majority", 32'(bus.majority), 32'd0);

    send(32'hAAAA_AAAA);
    a0 = last_acc;
    recv(0, 1'b0);
    send(32'h0000_0007);
    check("b2b_gap", last_acc - a0, 32'd6);
    recv(0, 1'b0);

`ifdef POPCOUNT_ACCUM_EN
    accum_clr = 1'b1;
    tick();
    accum_clr = 1'b0;
    check("accum_cleared", accum_count, 32'd0);
    send(32'h0000_00FF);
    recv(0, 1'b0);
    send(32'h0000_F0F0);
    recv(0, 1'b0);
    check("accum_sum", accum_count, 32'd16);
    send(32'h0000_0001);
    recv(0, 1'b1);
    check("accum_clr_priority", accum_count, 32'd0);
`endif

    check("no_ready_valid_overlap", 32'(overlap_viol), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
